mul_sign_ctrl: RTL

- Issue/retire controller for the 32-cycle unsigned shift-add multiplier in the M extension.
- Accepts MUL/MULH/MULHSU/MULHU requests from the execute stage and converts signed operands to magnitudes.
- Drives the multiplier's one-cycle issue pulse and waits for completion.
- Applies two's-complement sign correction to the 64-bit product, then returns the selected 32-bit word over a valid/ready response channel.

---
 rtl/mul_sign_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mul_sign_ctrl.sv
// Issue/retire controller for the 32-cycle unsigned shift-add multiplier.
// Converts signed operands to magnitudes, issues the multiplier, waits for
// completion, applies sign correction and returns the selected product word.
module mul_sign_ctrl #(
    parameter int unsigned TAG_W     = 5,
    parameter bit          FAST_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy,
    output logic             mul_in_valid,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic             mul_stallreq,
    input  logic [31:0]      mul_result_h,
    input  logic [31:0]      mul_result_l
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FIX,
        RESP,
        DRAIN
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               accept;
    logic               zero_hit;
    logic               sa;
    logic               sb;
    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic               neg_q;
    logic               op_hi_q;
    logic [TAG_W-1:0]   tag_q;
    logic [63:0]        product_q;
    logic [63:0]        p_fix;

    // Operand sign decode and magnitude conversion (0x80000000 stays as is).
    always_comb begin
        sa       = (req_op != 2'b11) && req_rs1[31];
        sb       = !req_op[1] && req_rs2[31];
        mag_a    = sa ? (~req_rs1 + 32'd1) : req_rs1;
        mag_b    = sb ? (~req_rs2 + 32'd1) : req_rs2;
        zero_hit = FAST_ZERO && ((req_rs1 == '0) || (req_rs2 == '0));
        accept   = (state == IDLE) && req_valid && !flush;
        p_fix    = neg_q ? (~product_q + 64'd1) : product_q;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush always wins over normal progress.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = zero_hit ? RESP : ISSUE;
            ISSUE:   state_nxt = flush ? DRAIN : WAIT;
            WAIT: begin
                if (flush)              state_nxt = DRAIN;
                else if (!mul_stallreq) state_nxt = FIX;
            end
            FIX:     state_nxt = flush ? IDLE : RESP;
            RESP:    if (flush || resp_ready) state_nxt = IDLE;
            DRAIN:   if (!mul_stallreq) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, product capture and sign-corrected result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_a     <= '0;
            mul_b     <= '0;
            neg_q     <= 1'b0;
            op_hi_q   <= 1'b0;
            tag_q     <= '0;
            product_q <= '0;
            resp_data <= '0;
            resp_tag  <= '0;
        end else begin
            if (accept) begin
                mul_a   <= mag_a;
                mul_b   <= mag_b;
                neg_q   <= sa ^ sb;
                op_hi_q <= (req_op != 2'b00);
                tag_q   <= req_tag;
                if (zero_hit) begin
                    resp_data <= '0;
                    resp_tag  <= req_tag;
                end
            end
            if ((state == WAIT) && !mul_stallreq && !flush) begin
                product_q <= {mul_result_h, mul_result_l};
            end
            if ((state == FIX) && !flush) begin
                resp_data <= op_hi_q ? p_fix[63:32] : p_fix[31:0];
                resp_tag  <= tag_q;
            end
        end
    end

    assign req_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign mul_in_valid = (state == ISSUE);
    assign resp_valid   = (state == RESP);

endmodule
